// File: rtl/gpc_pkg.sv
// Shared definitions for the (3;2) generalized parallel counter.
// Provides the per-lane input/output widths and a 3-bit popcount helper
// returning {carry, sum}.
package gpc_pkg;

  localparam int GPC3_2_IN_W  = 3;
  localparam int GPC3_2_OUT_W = 2;

  // Full-adder form of a 3-bit popcount: bit 0 is the sum, bit 1 the majority.
  function automatic logic [GPC3_2_OUT_W-1:0] popcount3(input logic [GPC3_2_IN_W-1:0] v);
    logic carry;
    logic sum;
    sum   = v[0] ^ v[1] ^ v[2];
    carry = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/gpc3_2_pipe_if.sv
// Column/result bundle for gpc3_2_pipe.
//   in_valid  : src0 carries a valid column set
//   src0      : 3 bits per lane, all weight 1
//   dst       : 2 bits per lane, {carry, sum}
//   out_valid : dst holds a valid result
// master drives columns and observes results; slave is the counter.
interface gpc3_2_pipe_if #(
  parameter int LANES = 1
);
  logic               in_valid;
  logic [3*LANES-1:0] src0;
  logic [2*LANES-1:0] dst;
  logic               out_valid;

  modport master (
    output in_valid,
    output src0,
    input  dst,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  src0,
    output dst,
    output out_valid
  );
endinterface

// File: rtl/gpc3_2_cell.sv
// Single-lane combinational (3;2) counter.
//   src[2:0] : three bits of equal weight
//   dst[1:0] : their count, dst[0] = sum (weight 1), dst[1] = carry (weight 2)
module gpc3_2_cell
  import gpc_pkg::*;
(
  input  logic [GPC3_2_IN_W-1:0]  src,
  output logic [GPC3_2_OUT_W-1:0] dst
);

  assign dst = popcount3(src);

endmodule

// File: rtl/gpc3_2_pipe.sv
// LANES independent (3;2) counters packed side by side, with an optional
// output register stage.
//   clk, rst_n : clock and async active-low reset (only used when REG_OUT=1)
//   bus        : slave side of gpc3_2_pipe_if (in_valid, src0 -> dst, out_valid)
// REG_OUT=1 gives latency 1 with dst held while in_valid is low;
// REG_OUT=0 is a pure combinational path.
module gpc3_2_pipe
  import gpc_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int REG_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  gpc3_2_pipe_if.slave bus
);

  logic [GPC3_2_OUT_W*LANES-1:0] cnt;

  // Lanes are fully independent: a lane's carry belongs to the next column of
  // the enclosing tree, never to the neighbouring lane here.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gpc3_2_cell u_cell (
      .src (bus.src0[GPC3_2_IN_W*i +: GPC3_2_IN_W]),
      .dst (cnt[GPC3_2_OUT_W*i +: GPC3_2_OUT_W])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    logic [GPC3_2_OUT_W*LANES-1:0] dst_q;
    logic                          valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dst_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          dst_q <= cnt;
        end
      end
    end

    assign bus.dst       = dst_q;
    assign bus.out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no function on the combinational path.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign bus.dst       = cnt;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_gpc3_2_pipe.sv
module tb_gpc3_2_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gpc3_2_pipe_if #(.LANES(1)) if1  ();
  gpc3_2_pipe_if #(.LANES(4)) if4r ();
  gpc3_2_pipe_if #(.LANES(4)) if4c ();

  gpc3_2_pipe #(.LANES(1), .REG_OUT(0)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gpc3_2_pipe #(.LANES(4), .REG_OUT(1)) u_r4 (.clk(clk), .rst_n(rst_n), .bus(if4r.slave));
  gpc3_2_pipe #(.LANES(4), .REG_OUT(0)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(if4c.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each lane is the arithmetic count of its three input bits.
  function automatic logic [7:0] ref4(input logic [11:0] s);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = int'(s[3*i]) + int'(s[3*i+1]) + int'(s[3*i+2]);
      r[2*i +: 2] = 2'(c);
    end
    return r;
  endfunction

  // Drive a column set into the registered instance and clock it once.
  task automatic step_r(input logic v, input logic [11:0] s);
    @(negedge clk);
    if4r.in_valid = v;
    if4r.src0     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4r.dst !== 8'h00 || if4r.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: dst=%h out_valid=%b, required dst=00 out_valid=0", if4r.dst, if4r.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (if4r.dst !== 8'h00 || if4r.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dst=%h out_valid=%b, required dst=00 out_valid=0", if4r.dst, if4r.out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [1:0] table_exp [8];
    logic [2:0] s;
    int         ref_sum;
    table_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    if1.in_valid = 1'b1;
    for (int v = 0; v < 8; v++) begin
      s = 3'(v);
      if1.src0 = s;
      #1;
      ref_sum = int'(s[0]) + int'(s[1]) + int'(s[2]);
      checks++;
      if (if1.dst !== table_exp[v] || int'(if1.dst) != ref_sum || if1.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL exhaustive src0=%b: dst=%0d out_valid=%b, required dst=%0d out_valid=1",
                 s, if1.dst, if1.out_valid, ref_sum);
      end
    end
    if1.in_valid = 1'b0;
    #1;
    checks++;
    if (if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL comb_valid: out_valid=%b, required 0", if1.out_valid);
    end
  endtask

  task automatic test_latency();
    step_r(1'b1, 12'h000);
    step_r(1'b0, 12'h000);
    @(negedge clk);
    if4r.in_valid = 1'b1;
    if4r.src0     = 12'hFFF;
    #1;
    checks++;
    if (if4r.dst !== 8'h00 || if4r.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_before: dst=%h out_valid=%b, required dst=00 out_valid=0", if4r.dst, if4r.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if4r.dst !== 8'hFF || if4r.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_after: dst=%h out_valid=%b, required dst=ff out_valid=1", if4r.dst, if4r.out_valid);
    end
  endtask

  task automatic test_hold();
    step_r(1'b1, 12'b101_101_101_101);
    checks++;
    if (if4r.dst !== 8'b10_10_10_10 || if4r.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_capture: dst=%b out_valid=%b, required dst=10101010 out_valid=1", if4r.dst, if4r.out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      step_r(1'b0, 12'h000);
      checks++;
      if (if4r.dst !== 8'b10_10_10_10 || if4r.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: dst=%b out_valid=%b, required dst=10101010 out_valid=0", k, if4r.dst, if4r.out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    step_r(1'b1, 12'hFFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4r.dst !== 8'h00 || if4r.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dst=%h out_valid=%b, required dst=00 out_valid=0", if4r.dst, if4r.out_valid);
    end
    #1;
    rst_n = 1'b1;
    // first edge after release must capture normally
    @(posedge clk);
    #1;
    checks++;
    if (if4r.dst !== 8'hFF || if4r.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_edge: dst=%h out_valid=%b, required dst=ff out_valid=1", if4r.dst, if4r.out_valid);
    end
  endtask

  task automatic test_lane_isolation();
    if4c.in_valid = 1'b1;
    if4c.src0     = 12'b111_000_110_001;
    #1;
    checks++;
    if (if4c.dst !== 8'b11_00_10_01 || if4c.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lanes_comb: dst=%b out_valid=%b, required dst=11001001 out_valid=1", if4c.dst, if4c.out_valid);
    end
    step_r(1'b1, 12'b111_000_110_001);
    checks++;
    if (if4r.dst !== 8'b11_00_10_01) begin
      errors++;
      $display("FAIL lanes_reg: dst=%b, required 11001001", if4r.dst);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_dst;
    logic        exp_v;
    logic        v;
    logic [11:0] s;
    exp_dst = if4r.dst === 8'b11_00_10_01 ? 8'b11_00_10_01 : 8'h00;
    exp_dst = 8'b11_00_10_01;
    for (int n = 0; n < 1000; n++) begin
      v = 1'($urandom_range(0, 3) != 0);
      s = 12'($urandom);
      if4c.in_valid = v;
      if4c.src0     = s;
      step_r(v, s);
      if (v) exp_dst = ref4(s);
      exp_v = v;
      checks++;
      if (if4r.dst !== exp_dst || if4r.out_valid !== exp_v) begin
        errors++;
        $display("FAIL random_reg cycle %0d: dst=%h out_valid=%b, required dst=%h out_valid=%b",
                 n, if4r.dst, if4r.out_valid, exp_dst, exp_v);
      end
      checks++;
      if (if4c.dst !== ref4(s) || if4c.out_valid !== v) begin
        errors++;
        $display("FAIL random_comb cycle %0d: dst=%h out_valid=%b, required dst=%h out_valid=%b",
                 n, if4c.dst, if4c.out_valid, ref4(s), v);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if1.in_valid  = 1'b0;
    if1.src0      = '0;
    if4r.in_valid = 1'b0;
    if4r.src0     = '0;
    if4c.in_valid = 1'b0;
    if4c.src0     = '0;

    test_reset();
    test_exhaustive();
    test_latency();
    test_hold();
    test_async_reset();
    test_lane_isolation();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
